// File: rtl/uart_tx_switch_sender.sv
// uart_tx_switch_sender: debounced key press sends the 7-bit switch value as one UART 8N1 frame.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx_switch_sender #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int BAUD            = 115200,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] data_in,
  input  logic       send_n,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [6:0] last_tx
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(CPB);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [BW-1:0] BLAST = BW'(CPB - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [1:0]    sync;
  logic          key;
  logic          press;
  logic [DW-1:0] dcnt;
  logic [2:0]    state;
  logic [BW-1:0] bcnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  // The counter only advances while a level change is pending, so any bounce back restarts it.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync  <= 2'b11;
      key   <= 1'b1;
      press <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync  <= {sync[0], send_n};
      press <= 1'b0;
      if (sync[1] == key) dcnt <= '0;
      else if (dcnt == DLAST) begin
        dcnt  <= '0;
        key   <= sync[1];
        press <= ~sync[1];
      end else dcnt <= dcnt + 1'b1;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      bcnt    <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      last_tx <= '0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        bcnt <= '0;
        if (press) begin
          shreg <= {1'b0, data_in};
          idx   <= '0;
          state <= START;
          tx    <= 1'b0;
          busy  <= 1'b1;
        end
      end else if (bcnt != BLAST) bcnt <= bcnt + 1'b1;
      else begin
        bcnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            idx   <= '0;
            tx    <= shreg[0];
          end
          DATA:
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shreg;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              idx <= idx + 3'd1;
              tx  <= shreg[idx + 3'd1];
            end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
`endif
          default: begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            last_tx <= shreg[6:0];
          end
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_switch_sender.sv
// tb_uart_tx_switch_sender: random switch values framed against a bit-level reference of the UART frame.
module tb_uart_tx_switch_sender;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       send_n = 1'b1;
  logic [6:0] data_in = '0;
  logic       tx, busy, tx_done;
  logic [6:0] last_tx;
  int n_chk = 0, n_pass = 0;
  always #5 clock = ~clock;
  uart_tx_switch_sender #(.CLK_FREQ(1000), .BAUD(100), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .send_n(send_n),
    .tx(tx), .busy(busy), .tx_done(tx_done), .last_tx(last_tx)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic frame_bit(input logic [6:0] v, input int i);
    logic [7:0] b;
    b = {1'b0, v};
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction
  task automatic wait_start(output bit seen, inout int hold);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      hold++;
      if (hold == 10) send_n = 1'b1;
      if (!tx) seen = 1;
    end
    check("start_seen", 32'(seen), 1);
  endtask
  task automatic send(input logic [6:0] v, input bit meddle, input bit extra);
    bit seen;
    int hold = 0, pulses = 0;
    data_in = v;
    send_n = 1'b0;
    wait_start(seen, hold);
    if (!seen) begin
      send_n = 1'b1;
      return;
    end
    for (int c = 0; c < NB * CPB; c++) begin
      if (c > 0) begin
        @(negedge clock);
        hold++;
        if (hold == 10) send_n = 1'b1;
      end
      if (meddle && c == 3 * CPB) data_in = 7'($urandom);
      if (extra && c == 4 * CPB) begin
        send_n = 1'b0;
        data_in = 7'h7f;
      end
      if (extra && c == 6 * CPB) send_n = 1'b1;
      if (tx_done) pulses++;
      if (c % CPB == CPB / 2) begin
        check($sformatf("bit%0d_of_%0h", c / CPB, v), tx, frame_bit(v, c / CPB));
        check("busy_mid", busy, 1);
      end
    end
    check("done_early", pulses, 0);
    @(negedge clock);
    check("tx_done", tx_done, 1);
    check("busy_end", busy, 0);
    check("last_tx", last_tx, v);
    check("tx_idle", tx, 1);
    @(negedge clock);
    check("done_one_cycle", tx_done, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit any_busy, seen;
    int hold;
    logic [6:0] v;
    repeat (3) @(negedge clock);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_done", tx_done, 0);
      check("idle_last", last_tx, 0);
    end
    send(7'h35, 0, 0);
    repeat (20) @(negedge clock);
    any_busy = 0;
    for (int g = 0; g < 3; g++) begin
      send_n = 1'b0;
      repeat (2) begin @(negedge clock); any_busy |= busy | ~tx; end
      send_n = 1'b1;
      repeat (6) begin @(negedge clock); any_busy |= busy | ~tx; end
    end
    repeat (40) begin @(negedge clock); any_busy |= busy | ~tx; end
    check("glitch_no_frame", 32'(any_busy), 0);
    send(7'h35, 0, 1);
    any_busy = 0;
    repeat (100) begin @(negedge clock); any_busy |= busy | ~tx; end
    check("press_dropped", 32'(any_busy), 0);
    check("last_after_drop", last_tx, 7'h35);
    for (int r = 0; r < 6; r++) begin
      send(7'($urandom), r[0], 0);
      repeat (20) @(negedge clock);
    end
    v = 7'($urandom);
    data_in = v;
    send_n = 1'b0;
    hold = 0;
    wait_start(seen, hold);
    send_n = 1'b1;
    repeat (35) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_last", last_tx, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    send(7'($urandom), 0, 0);
    repeat (10) @(negedge clock);
    send(7'h07, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
